instr_cache_frontend: RTL and testbench

// Dual-read-port, direct-mapped instruction cache feeding the two-wide instruction loader.
// - Upstream side: a word-serial memory bus.
// - Downstream side: the loader's i_cache_instr/i_cache_hit and o_cache_address/o_cache_read pairs.
// - A single miss-fill FSM refills one line at a time.
// - Hits are served every cycle, including while a fill is in progress.

---
 rtl/instr_cache_frontend.sv | 148 ++++++++++++++
 tb/tb_instr_cache_frontend.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/instr_cache_frontend.sv
// Direct-mapped, dual-read-port instruction cache with a single
// word-serial miss-fill engine; hits keep flowing while a line fills.
module instr_cache_frontend #(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address [2],
  input  logic        i_read [2],
  output logic [31:0] o_instr [2],
  output logic        o_hit [2],
  input  logic        i_flush,
  output logic [31:0] o_mem_address,
  output logic        o_mem_read,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_ready,
  output logic        o_busy
);

  localparam int INDEX_BITS  = $clog2(SETS);
  localparam int WORD_BITS   = $clog2(LINE_WORDS);
  localparam int OFFSET_BITS = WORD_BITS + 2;
  localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int TAG_LSB     = OFFSET_BITS + INDEX_BITS;
  localparam logic [WORD_BITS-1:0] LAST = WORD_BITS'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

  state_t state, state_nx;

  logic [SETS-1:0]       valid;
  logic [TAG_BITS-1:0]   tag_mem [SETS];
  logic [31:0]           data_mem [SETS][LINE_WORDS];
  logic [31:0]           line_buf [LINE_WORDS];

  logic [TAG_BITS-1:0]   fill_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [WORD_BITS-1:0]  beat;
  logic                  drop;
  logic                  commit_we;
  logic                  start;

  logic [TAG_BITS-1:0]   tag [2];
  logic [INDEX_BITS-1:0] idx [2];
  logic [WORD_BITS-1:0]  word [2];
  logic                  hit [2];
  logic                  miss [2];
  logic                  unused_lsb;

  assign unused_lsb = ^{i_address[0][1:0], i_address[1][1:0]};

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      tag[n]  = i_address[n][31:TAG_LSB];
      idx[n]  = i_address[n][OFFSET_BITS +: INDEX_BITS];
      word[n] = i_address[n][2 +: WORD_BITS];
      hit[n]  = i_read[n] && valid[idx[n]] &&
                (tag_mem[idx[n]] == tag[n]);
      miss[n] = i_read[n] && !hit[n];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < 2; n++) begin
        o_hit[n]   <= 1'b0;
        o_instr[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        o_hit[n] <= hit[n];
        if (hit[n]) o_instr[n] <= data_mem[idx[n]][word[n]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!i_flush && (miss[0] || miss[1])) begin
          state_nx = FILL;
          start    = 1'b1;
        end
      end
      FILL: begin
        if (i_mem_ready && beat == LAST) state_nx = COMMIT;
      end
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_tag <= '0;
      fill_idx <= '0;
      beat     <= '0;
      drop     <= 1'b0;
    end else begin
      if (start) begin
        fill_tag <= miss[0] ? tag[0] : tag[1];
        fill_idx <= miss[0] ? idx[0] : idx[1];
        beat     <= '0;
        drop     <= 1'b0;
      end
      if (state == FILL) begin
        if (i_mem_ready) beat <= beat + WORD_BITS'(1);
        if (i_flush)     drop <= 1'b1;
      end
      if (state == COMMIT) drop <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == FILL && i_mem_ready) line_buf[beat] <= i_mem_data;
  end

  // A flush during the burst or in the commit cycle discards the line.
  assign commit_we = (state == COMMIT) && !drop && !i_flush;

  always_ff @(posedge clk) begin
    if (commit_we) begin
      tag_mem[fill_idx] <= fill_tag;
      for (int w = 0; w < LINE_WORDS; w++)
        data_mem[fill_idx][w] <= line_buf[w];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         valid <= '0;
    else if (i_flush)   valid <= '0;
    else if (commit_we) valid[fill_idx] <= 1'b1;
  end

  assign o_busy        = (state != IDLE);
  assign o_mem_read    = (state == FILL);
  assign o_mem_address = o_mem_read ?
                         {fill_tag, fill_idx, beat, 2'b00} : 32'h0;

endmodule

// File: tb/tb_instr_cache_frontend.sv
// Directed bench for instr_cache_frontend: scoreboard of expected
// hit/instr per cycle plus fill-bus and status checks.
module tb_instr_cache_frontend;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_address [2];
  logic        i_read [2];
  logic [31:0] o_instr [2];
  logic        o_hit [2];
  logic        i_flush;
  logic [31:0] o_mem_address;
  logic        o_mem_read;
  logic [31:0] i_mem_data;
  logic        i_mem_ready;
  logic        o_busy;

  instr_cache_frontend dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read),
    .o_instr(o_instr), .o_hit(o_hit),
    .i_flush(i_flush),
    .o_mem_address(o_mem_address), .o_mem_read(o_mem_read),
    .i_mem_data(i_mem_data), .i_mem_ready(i_mem_ready),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        h0;
    logic        h1;
    logic [31:0] d0;
    logic [31:0] d1;
  } exp_t;

  exp_t        sb [$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last0, last1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h10) return 32'hA0 + {28'h0, a[3:2]};
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, memory answers the current beat,
  // expected lookup result is queued and compared at the next negedge.
  task automatic cyc(input logic r0, input logic [31:0] a0,
                     input logic r1, input logic [31:0] a1,
                     input logic fl, input logic stall,
                     input logic h0, input logic h1);
    exp_t e;
    i_read[0]    = r0;
    i_address[0] = a0;
    i_read[1]    = r1;
    i_address[1] = a1;
    i_flush      = fl;
    i_mem_ready  = o_mem_read && !stall;
    i_mem_data   = o_mem_read ? mem_word(o_mem_address) : 32'h0;
    if (h0) last0 = mem_word(a0);
    if (h1) last1 = mem_word(a1);
    e = '{h0, h1, last0, last1};
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk("hit0", {31'h0, o_hit[0]}, {31'h0, e.h0});
    chk("hit1", {31'h0, o_hit[1]}, {31'h0, e.h1});
    chk("instr0", o_instr[0], e.d0);
    chk("instr1", o_instr[1], e.d1);
  endtask

  task automatic do_fill(input logic [31:0] a);
    for (int j = 0; j <= 6; j++) cyc(1, a, 0, 0, 0, 0, j == 6, 0);
  endtask

  initial begin
    reset = 1'b0;
    i_read[0] = 0; i_read[1] = 0;
    i_address[0] = 0; i_address[1] = 0;
    i_flush = 0; i_mem_data = 0; i_mem_ready = 0;
    last0 = 0; last1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_hit0", {31'h0, o_hit[0]}, 32'h0);
    chk("rst_instr0", o_instr[0], 32'h0);
    chk("rst_memrd", {31'h0, o_mem_read}, 32'h0);
    chk("rst_memaddr", o_mem_address, 32'h0);
    chk("rst_busy", {31'h0, o_busy}, 32'h0);
    reset = 1'b1;

    // cold miss and fill of 0x100
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("t1_rd", {31'h0, o_mem_read}, 32'h1);
    chk("t1_addr0", o_mem_address, 32'h100);
    chk("t1_busy", {31'h0, o_busy}, 32'h1);
    for (int j = 1; j <= 4; j++) begin
      cyc(1, 32'h104, 0, 0, 0, 0, 0, 0);
      if (j < 4) chk("t1_addr", o_mem_address, 32'h100 + 32'(4 * j));
      else       chk("t1_commit_rd", {31'h0, o_mem_read}, 32'h0);
    end
    cyc(1, 32'h104, 0, 0, 0, 0, 0, 0);
    chk("t1_idle", {31'h0, o_busy}, 32'h0);
    cyc(1, 32'h104, 0, 0, 0, 0, 1, 0);

    // dual-port hit on a warm line
    cyc(1, 32'h108, 1, 32'h10C, 0, 0, 1, 1);
    chk("t2_rd", {31'h0, o_mem_read}, 32'h0);

    // two cold lines: port 0 filled first, port 1 afterwards
    for (int t = 0; t <= 12; t++) begin
      cyc(t <= 6, 32'h200, 1, 32'h300, 0, 0, t == 6, t == 12);
      if (t == 0) chk("t3_first", o_mem_address, 32'h200);
      if (t == 6) chk("t3_second", o_mem_address, 32'h300);
    end

    // fill with a 3-cycle stall on beat 2
    for (int j = 0; j <= 9; j++) begin
      logic [31:0] ea;
      cyc(1, 32'h408, 0, 0, 0, j >= 3 && j <= 5, j == 9, 0);
      ea = (j == 0) ? 32'h400 : (j == 1) ? 32'h404 :
           (j <= 5) ? 32'h408 : 32'h40C;
      if (j <= 6) chk("t4_addr", o_mem_address, ea);
    end
    cyc(1, 32'h400, 1, 32'h40C, 0, 0, 1, 1);

    // flush in the middle of a fill of 0x500 (aliases 0x400)
    cyc(1, 32'h500, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h404, 0, 0, 0, 0, 1, 0);
    cyc(1, 32'h404, 0, 0, 1, 0, 1, 0);
    cyc(1, 32'h404, 0, 0, 0, 0, 0, 0);
    chk("t5_still_busy", {31'h0, o_busy}, 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_commit_rd", {31'h0, o_mem_read}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_idle", {31'h0, o_busy}, 32'h0);
    cyc(1, 32'h500, 1, 32'h100, 0, 0, 0, 0);
    chk("t5_refill", o_mem_address, 32'h500);
    for (int j = 7; j <= 12; j++) cyc(1, 32'h500, 0, 0, 0, 0, j == 12, 0);

    // reset in the middle of a burst
    do_fill(32'h100);
    cyc(1, 32'h600, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_beat1", o_mem_address, 32'h604);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_rd", {31'h0, o_mem_read}, 32'h0);
    chk("t6_async_busy", {31'h0, o_busy}, 32'h0);
    i_mem_ready = 0;
    @(negedge clk);
    reset = 1'b1;
    last0 = 0; last1 = 0;
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("t6_miss_fill", o_mem_address, 32'h100);
    chk("t6_miss_rd", {31'h0, o_mem_read}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
